// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit sequencer: sample width, FSM states and
// the stereo pair word stored in the sample FIFO.
package i2s_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } pair_t;

    localparam pair_t SILENCE = '0;

endpackage

// File: rtl/i2s_tx_ctrl_if.sv
// Bundle between the S/PDIF receive path / I2S transmitter (master) and the
// transmit sequencer (slave).
interface i2s_tx_ctrl_if #(
    parameter int DEPTH = 8
);
    import i2s_pkg::*;

    logic                       enable;
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] in_left;
    logic signed [SAMPLE_W-1:0] in_right;
    logic                       next_sample;
    logic                       strobe;
    logic signed [SAMPLE_W-1:0] sample_left;
    logic signed [SAMPLE_W-1:0] sample_right;
    logic                       playing;
    logic                       underrun;
    logic                       overrun;
    logic [$clog2(DEPTH):0]     level;

    modport master (
        output enable, in_valid, in_left, in_right, next_sample,
        input  strobe, sample_left, sample_right, playing, underrun, overrun, level
    );

    modport slave (
        input  enable, in_valid, in_left, in_right, next_sample,
        output strobe, sample_left, sample_right, playing, underrun, overrun, level
    );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous stereo-pair FIFO with registered occupancy and synchronous flush.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  pair_t                  din,
    output pair_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    pair_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: bit-rate strobe divider, start-up priming and
// underrun/overrun handling around a stereo-pair FIFO.
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int DIV         = 8,
    parameter int DEPTH       = 8,
    parameter int START_LEVEL = 4
) (
    input logic          clk,
    input logic          rst,
    i2s_tx_ctrl_if.slave bus
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] div_cnt;
    logic          strobe;
    state_t        state;
    pair_t         sample_out;
    pair_t         head;
    pair_t         in_pair;
    logic          playing;
    logic          underrun;
    logic          overrun;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          flush;
    logic          push_req;
    logic          pop_req;
    logic          starve;

    assign in_pair  = '{left: bus.in_left, right: bus.in_right};
    assign flush    = !bus.enable || (state == IDLE);
    assign push_req = bus.in_valid && bus.enable && (state != IDLE);
    assign pop_req  = bus.next_sample && (state == RUN) && !fifo_empty;
    assign starve   = bus.next_sample && (state == RUN) && fifo_empty;

    sample_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .push (push_req),
        .pop  (pop_req),
        .din  (in_pair),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty),
        .level(fifo_level)
    );

    // Free-running divider keeps BCLK/LRCLK alive even while muted.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            strobe  <= 1'b0;
        end else begin
            strobe  <= (div_cnt == CW'(DIV - 1));
            div_cnt <= (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            playing    <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            sample_out <= SILENCE;
        end else begin
            underrun <= starve;
            overrun  <= push_req && fifo_full && !pop_req;
            // The load for the next frame happens even if enable drops this cycle.
            if (bus.next_sample) begin
                sample_out <= pop_req ? head : SILENCE;
            end
            if (!bus.enable) begin
                state   <= IDLE;
                playing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= FILL;
                        playing <= 1'b0;
                    end
                    FILL: begin
                        if (fifo_level >= LW'(START_LEVEL)) begin
                            state   <= RUN;
                            playing <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (starve) begin
                            state   <= FILL;
                            playing <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        playing <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.strobe       = strobe;
    assign bus.sample_left  = sample_out.left;
    assign bus.sample_right = sample_out.right;
    assign bus.playing      = playing;
    assign bus.underrun     = underrun;
    assign bus.overrun      = overrun;
    assign bus.level        = fifo_level;

endmodule

// File: doc/i2s_tx_ctrl.md
# i2s_tx_ctrl

Sequencer and sample buffer that feeds the 16-bit I2S transmitter. It generates the transmitter's bit-rate `strobe` enable from `clk` and buffers left/right pairs arriving from the S/PDIF decoder in a small FIFO. It answers the transmitter's `next_sample` request with a stable pair, and manages start-up priming and underrun/overrun recovery. It sits between the S/PDIF receive path and the I2S transmitter, and is the only block that drives the transmitter's `strobe`, `sample_left` and `sample_right` inputs.

## Interface
- `DIV`, 8: `clk` cycles per `strobe` pulse (one strobe per I2S bit); legal range ≥2.
- `DEPTH`, 8: FIFO depth in stereo pairs; power of two, ≥2.
- `START_LEVEL`, 4: FIFO level required before playback starts; 1..`DEPTH`.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  playback enable, level-sensitive.
- `in_valid`  in  1  one-cycle pulse: `in_left`/`in_right` hold a new pair.
- `in_left`  in  16  left sample, two's complement.
- `in_right`  in  16  right sample.
- `next_sample`  in  1  from transmitter: the transmitter latches `sample_left`/`sample_right` on this edge.
- `strobe`  out  1  bit-rate enable to the transmitter, registered.
- `sample_left`  out  16  pair presented to the transmitter, registered.
- `sample_right`  out  16  registered.
- `playing`  out  1  high in state RUN.
- `underrun`  out  1  one-cycle pulse.
- `overrun`  out  1  one-cycle pulse.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Strobe divider:
  - Counter runs 0..`DIV`-1 and wraps; runs whenever `rst`=0, independent of `enable`.
  - `strobe` is high for exactly one cycle per `DIV` cycles.
  - This keeps LRCLK/BCLK running while muted.
- FIFO write path:
  - `in_valid` pushes {`in_left`,`in_right`} unless the FIFO is full.
  - A push into a full FIFO drops the pair and pulses `overrun` in the next cycle; FIFO contents are unchanged.
  - A push and a pop in the same cycle when full: the pop frees space, so the push is accepted and no `overrun` is raised.
  - A push and a pop in the same cycle when empty is an underrun; the pushed pair is stored.
- Output registers hold the pair the transmitter will latch at the next `next_sample`. On each `next_sample` edge, the registers load the pair for the following frame. This gives one frame of pre-load latency.
- States (FSM):
  - IDLE:
    - FIFO flushed (level forced to 0); input pushes ignored.
    - Each `next_sample` loads 0/0.
    - `enable`=1 → FILL.
  - FILL:
    - Pushes accepted; each `next_sample` loads 0/0.
    - `level` ≥ `START_LEVEL` → RUN.
  - RUN:
    - Each `next_sample` pops the FIFO head into the output registers.
    - If the FIFO is empty on `next_sample`: load 0/0, pulse `underrun` in the next cycle, go to FILL.
  - Any state with `enable`=0 → IDLE in the next cycle.
  - `enable` dropping in the same cycle as `next_sample`: the pop or zero-load still occurs, then the FSM goes to IDLE.
- `level` is the registered occupancy, updated by push minus pop each cycle. Read and write pointers wrap modulo `DEPTH`.

## Timing
- Reset values:
  - divider counter 0; `strobe` 0;
  - `sample_left`/`sample_right` 0;
  - FIFO empty, `level` 0;
  - state IDLE; `playing`, `underrun`, `overrun` 0.
- Reset asserted mid-operation clears everything above on the next edge; partial frames are discarded.
- First `strobe` is high in the `DIV`-th cycle after the first edge with `rst`=0, then every `DIV` cycles.
- Push latency: a pair pushed at edge N is counted in `level` after edge N.
- The pair becomes visible on the sample outputs at the first `next_sample` edge after it is at the FIFO head in RUN.
- FILL→RUN: `playing` rises one cycle after `level` reaches `START_LEVEL`.
- `next_sample` arrives at most once per 32·`DIV` cycles; the block has no requirement to handle faster requests.

## Structure
- Package `i2s_pkg`:
  - `SAMPLE_W`=16;
  - state enum {IDLE, FILL, RUN};
  - stereo pair typedef (32 bits, left in the MSBs).
- Sub-module `sample_fifo`: synchronous FIFO, width 2·`SAMPLE_W`, parameter `DEPTH`, with push/pop/full/empty/level and a synchronous flush.
- FSM, divider and output registers live in `i2s_tx_ctrl`.

## Test plan
- **Divider:** `DIV`=4, release reset → `strobe` high in cycles 4, 8, 12…, never two adjacent cycles.
- **Priming:** `enable`=1, push 4 pairs (0x1111/0x2222…) → `playing` rises after the 4th push. The next `next_sample` loads 0x1111/0x2222; pairs then come out in order on subsequent requests.
- **Underrun:** in RUN with 1 pair left, issue 2 `next_sample` → second loads 0/0, `underrun` pulses once, state returns to FILL, `playing`=0.
- **Overrun:** `DEPTH`=8, push 9 pairs with no pops → 9th dropped, `overrun` pulses once, `level`=8. Simultaneous push+pop when full → no `overrun`, `level` stays 8.
- **Disable:** `enable`=0 mid-RUN with level 5 → IDLE next cycle, `level`=0, subsequent `next_sample` loads 0/0, `strobe` keeps running.
- **Reset:** assert `rst` one cycle mid-frame → all outputs at reset values, first `strobe` `DIV` cycles after release.
